// File: rtl/muldiv_sequencer_pkg.sv
// Shared ALU opcode encoding plus the multiply/divide state type and decode helpers.
package muldiv_sequencer_pkg;

  // ALU opcodes, same encoding the combinational ALU and the control unit use
  localparam logic [4:0] OPAND    = 5'd0;
  localparam logic [4:0] OPOR     = 5'd1;
  localparam logic [4:0] OPXOR    = 5'd2;
  localparam logic [4:0] OPADD    = 5'd3;
  localparam logic [4:0] OPSUB    = 5'd4;
  localparam logic [4:0] OPSLT    = 5'd5;
  localparam logic [4:0] OPSLTU   = 5'd6;
  localparam logic [4:0] OPSLL    = 5'd7;
  localparam logic [4:0] OPSRL    = 5'd8;
  localparam logic [4:0] OPSRA    = 5'd9;
  localparam logic [4:0] OPLUI    = 5'd10;
  localparam logic [4:0] OPMUL    = 5'd11;
  localparam logic [4:0] OPMULH   = 5'd12;
  localparam logic [4:0] OPMULHU  = 5'd13;
  localparam logic [4:0] OPMULHSU = 5'd14;
  localparam logic [4:0] OPDIV    = 5'd15;
  localparam logic [4:0] OPDIVU   = 5'd16;
  localparam logic [4:0] OPREM    = 5'd17;
  localparam logic [4:0] OPREMU   = 5'd18;

  localparam logic [63:0] ZERO = 64'd0;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PREP = 3'd1,
    ST_CALC = 3'd2,
    ST_FIX  = 3'd3,
    ST_DONE = 3'd4
  } muldiv_state_t;

  // True for any opcode handled by the multi-cycle unit instead of the ALU
  function automatic logic is_muldiv(input logic [4:0] op);
    return op inside {OPMUL, OPMULH, OPMULHU, OPMULHSU, OPDIV, OPDIVU, OPREM, OPREMU};
  endfunction

  // True for the four division-family opcodes
  function automatic logic is_div(input logic [4:0] op);
    return op inside {OPDIV, OPDIVU, OPREM, OPREMU};
  endfunction

  // Operand A is interpreted as two's complement for these opcodes
  function automatic logic op_signed_a(input logic [4:0] op);
    return op inside {OPMUL, OPMULH, OPMULHSU, OPDIV, OPREM};
  endfunction

  // Operand B is interpreted as two's complement for these opcodes
  function automatic logic op_signed_b(input logic [4:0] op);
    return op inside {OPMUL, OPMULH, OPDIV, OPREM};
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the unsigned shift-add multiplier or restoring divider.
// Multiply: accumulator is {partial product high, multiplier-shifted low}.
// Divide:   accumulator is {partial remainder, remaining dividend bits}.
module muldiv_step #(
  parameter int WIDTH = 64
) (
  input  logic               i_mode,
  input  logic [2*WIDTH-1:0] i_acc,
  input  logic [WIDTH-1:0]   i_operand,
  input  logic               i_bit,
  output logic [2*WIDTH-1:0] o_acc,
  output logic               o_qBit
);

  logic [WIDTH:0] w_sum;
  logic [WIDTH:0] w_shifted;
  logic [WIDTH:0] w_trial;

  // Single iteration: add-and-shift-right for multiply, shift-and-trial-subtract for divide
  always_comb begin
    w_sum     = '0;
    w_shifted = '0;
    w_trial   = '0;
    o_acc     = '0;
    o_qBit    = 1'b0;
    if (i_mode) begin
      w_shifted = i_acc[2*WIDTH-1:WIDTH-1];
      w_trial   = w_shifted - {1'b0, i_operand};
      o_qBit    = ~w_trial[WIDTH];
      o_acc     = {(o_qBit ? w_trial[WIDTH-1:0] : w_shifted[WIDTH-1:0]),
                   i_acc[WIDTH-2:0], 1'b0};
    end else begin
      w_sum = {1'b0, i_acc[2*WIDTH-1:WIDTH]} + (i_bit ? {1'b0, i_operand} : '0);
      o_acc = {w_sum, i_acc[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle multiply/divide unit with busy/done handshake for the LEGv8 datapath.
// Fixed latency for every opcode: PREP, WIDTH CALC cycles, FIX, then DONE.
module muldiv_sequencer
  import muldiv_sequencer_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic             iCLK,
  input  logic             iRST,
  input  logic             iStart,
  input  logic [4:0]       iControl,
  input  logic [WIDTH-1:0] iA,
  input  logic [WIDTH-1:0] iB,
  output logic             oBusy,
  output logic             oDone,
  output logic [WIDTH-1:0] oResult
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [WIDTH-1:0] MOST_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

  muldiv_state_t r_state;
  muldiv_state_t w_stateNext;

  logic [4:0]         r_op;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic               r_negA;
  logic               r_negB;
  logic               r_divZero;
  logic               r_overflow;
  logic [WIDTH-1:0]   r_operand;
  logic [WIDTH-1:0]   r_mplier;
  logic [WIDTH-1:0]   r_quot;
  logic [2*WIDTH-1:0] r_acc;
  logic [CNT_W-1:0]   r_count;
  logic               r_busy;
  logic               r_done;
  logic [WIDTH-1:0]   r_result;

  logic               w_accept;
  logic               w_busyNext;
  logic               w_doneNext;
  logic               w_loadResult;
  logic               w_isDiv;
  logic               w_negA;
  logic               w_negB;
  logic [WIDTH-1:0]   w_magA;
  logic [WIDTH-1:0]   w_magB;
  logic [2*WIDTH-1:0] w_stepAcc;
  logic               w_qBit;
  logic [2*WIDTH-1:0] w_product;
  logic [WIDTH-1:0]   w_quotient;
  logic [WIDTH-1:0]   w_remainder;
  logic [WIDTH-1:0]   w_result;

  // Iteration kernel; operand is the multiplicand or the divisor depending on mode
  muldiv_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .i_mode   (w_isDiv),
    .i_acc    (r_acc),
    .i_operand(r_operand),
    .i_bit    (r_mplier[0]),
    .o_acc    (w_stepAcc),
    .o_qBit   (w_qBit)
  );

  // Decode the latched opcode into signedness and operand magnitudes
  always_comb begin
    w_isDiv = is_div(r_op);
    w_negA  = op_signed_a(r_op) & r_a[WIDTH-1];
    w_negB  = op_signed_b(r_op) & r_b[WIDTH-1];
    w_magA  = w_negA ? -r_a : r_a;
    w_magB  = w_negB ? -r_b : r_b;
  end

  // Sequencer state register
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Next-state logic and the values the registered outputs take on the next edge
  always_comb begin
    w_stateNext = r_state;
    w_accept    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (iStart && is_muldiv(iControl)) begin
          w_stateNext = ST_PREP;
          w_accept    = 1'b1;
        end
      end
      ST_PREP: w_stateNext = ST_CALC;
      ST_CALC: begin
        if (r_count == LAST_ITER) begin
          w_stateNext = ST_FIX;
        end
      end
      ST_FIX:  w_stateNext = ST_DONE;
      ST_DONE: w_stateNext = ST_IDLE;
      default: w_stateNext = ST_IDLE;
    endcase
    w_busyNext   = (w_stateNext != ST_IDLE);
    w_doneNext   = (w_stateNext == ST_DONE);
    w_loadResult = (r_state == ST_FIX);
  end

  // Operand latch, preparation and the per-cycle iteration of the datapath
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      r_op       <= '0;
      r_a        <= '0;
      r_b        <= '0;
      r_negA     <= 1'b0;
      r_negB     <= 1'b0;
      r_divZero  <= 1'b0;
      r_overflow <= 1'b0;
      r_operand  <= '0;
      r_mplier   <= '0;
      r_quot     <= '0;
      r_acc      <= '0;
      r_count    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_op <= iControl;
            r_a  <= iA;
            r_b  <= iB;
          end
        end
        ST_PREP: begin
          r_negA     <= w_negA;
          r_negB     <= w_negB;
          r_operand  <= w_isDiv ? w_magB : w_magA;
          r_mplier   <= w_magB;
          r_acc      <= w_isDiv ? {{WIDTH{1'b0}}, w_magA} : '0;
          r_quot     <= '0;
          r_count    <= '0;
          r_divZero  <= w_isDiv && (r_b == '0);
          r_overflow <= ((r_op == OPDIV) || (r_op == OPREM)) &&
                        (r_a == MOST_NEG) && (r_b == '1);
        end
        ST_CALC: begin
          r_acc    <= w_stepAcc;
          r_quot   <= {r_quot[WIDTH-2:0], w_qBit};
          r_mplier <= r_mplier >> 1;
          r_count  <= r_count + CNT_ONE;
        end
        default: begin
        end
      endcase
    end
  end

  // Sign correction, special-case overrides and high/low selection of the final result
  always_comb begin
    w_product   = (r_negA ^ r_negB) ? -r_acc : r_acc;
    w_quotient  = (r_negA ^ r_negB) ? -r_quot : r_quot;
    w_remainder = r_negA ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
    w_result    = '0;
    case (r_op)
      OPMUL: w_result = w_product[WIDTH-1:0];
      OPMULH, OPMULHU, OPMULHSU: w_result = w_product[2*WIDTH-1:WIDTH];
      OPDIV, OPDIVU: begin
        if (r_divZero) begin
          w_result = '1;
        end else if (r_overflow) begin
          w_result = r_a;
        end else begin
          w_result = w_quotient;
        end
      end
      OPREM, OPREMU: begin
        if (r_divZero) begin
          w_result = r_a;
        end else if (r_overflow) begin
          w_result = '0;
        end else begin
          w_result = w_remainder;
        end
      end
      default: w_result = '0;
    endcase
  end

  // Registered handshake and result; the result holds until the next operation finishes
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_result <= '0;
    end else begin
      r_busy <= w_busyNext;
      r_done <= w_doneNext;
      if (w_loadResult) begin
        r_result <= w_result;
      end
    end
  end

  assign oBusy   = r_busy;
  assign oDone   = r_done;
  assign oResult = r_result;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: directed corner cases, protocol and reset
// checks, then randomized operations compared against a wide-arithmetic reference.
module tb_muldiv_sequencer;
  import muldiv_sequencer_pkg::*;

  localparam int W       = 64;
  localparam int LATENCY = W + 2;
  localparam int MAX_WAIT = 200;
  localparam logic [W-1:0] MIN_NEG = {1'b1, {(W-1){1'b0}}};

  logic         iCLK = 1'b0;
  logic         iRST = 1'b1;
  logic         iStart = 1'b0;
  logic [4:0]   iControl = OPADD;
  logic [W-1:0] iA = '0;
  logic [W-1:0] iB = '0;
  logic         oBusy;
  logic         oDone;
  logic [W-1:0] oResult;

  int testCount = 0;
  int failCount = 0;
  logic [W-1:0] lastRes;

  muldiv_sequencer #(.WIDTH(W)) dut (
    .iCLK    (iCLK),
    .iRST    (iRST),
    .iStart  (iStart),
    .iControl(iControl),
    .iA      (iA),
    .iB      (iB),
    .oBusy   (oBusy),
    .oDone   (oDone),
    .oResult (oResult)
  );

  always #5 iCLK = ~iCLK;

  // Reference result from plain wide arithmetic and the architectural special cases
  function automatic logic [W-1:0] refModel(input logic [4:0] op, input logic [W-1:0] a,
                                            input logic [W-1:0] b);
    logic signed [127:0] sa, sb, ua, ub, prod;
    longint sdA, sdB;
    logic ovf;
    sa  = {{64{a[63]}}, a};
    sb  = {{64{b[63]}}, b};
    ua  = {64'd0, a};
    ub  = {64'd0, b};
    sdA = a;
    sdB = b;
    ovf = (a == MIN_NEG) && (b == '1);
    case (op)
      OPMUL:    begin prod = sa * sb; return prod[63:0];   end
      OPMULH:   begin prod = sa * sb; return prod[127:64]; end
      OPMULHU:  begin prod = ua * ub; return prod[127:64]; end
      OPMULHSU: begin prod = sa * ub; return prod[127:64]; end
      OPDIV:    return (b == 0) ? '1 : (ovf ? a : 64'(sdA / sdB));
      OPDIVU:   return (b == 0) ? '1 : a / b;
      OPREM:    return (b == 0) ? a : (ovf ? '0 : 64'(sdA % sdB));
      OPREMU:   return (b == 0) ? a : a % b;
      default:  return '0;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    testCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Run one operation to completion and check result, latency, busy and the return to idle
  task automatic applyStimulus(input string tag, input logic [4:0] op, input logic [W-1:0] a,
                               input logic [W-1:0] b, input bit holdStart, input bit scramble);
    logic [W-1:0] exp;
    int lat;
    bit busyOk;
    exp    = refModel(op, a, b);
    lat    = -1;
    busyOk = 1'b1;
    @(negedge iCLK);
    iStart   = 1'b1;
    iControl = op;
    iA       = a;
    iB       = b;
    @(posedge iCLK);
    #1;
    if (!holdStart) iStart = 1'b0;
    for (int j = 0; j < MAX_WAIT; j++) begin
      @(negedge iCLK);
      if (scramble && j == 20) begin
        iA       = {$urandom, $urandom};
        iB       = {$urandom, $urandom};
        iControl = OPADD;
      end
      if (!oBusy) busyOk = 1'b0;
      if (oDone) begin
        lat = j;
        break;
      end
    end
    lastRes = oResult;
    checkOutput({tag, "_result"}, oResult, exp);
    checkOutput({tag, "_latency"}, 64'(lat), 64'(LATENCY));
    checkOutput({tag, "_busy"}, {63'd0, busyOk}, 64'd1);
    @(negedge iCLK);
    iStart = 1'b0;
    checkOutput({tag, "_idle"}, {62'd0, oBusy, oDone}, 64'd0);
    @(negedge iCLK);
    checkOutput({tag, "_noreaccept"}, {62'd0, oBusy, oDone}, 64'd0);
  endtask

  initial begin
    logic [4:0] opList [8];
    logic [4:0] op;
    logic [W-1:0] a, b;
    bit sawActivity;
    int donePulses;

    opList = '{OPMUL, OPMULH, OPMULHU, OPMULHSU, OPDIV, OPDIVU, OPREM, OPREMU};

    repeat (3) @(negedge iCLK);
    checkOutput("reset_busy", {63'd0, oBusy}, 64'd0);
    checkOutput("reset_done", {63'd0, oDone}, 64'd0);
    checkOutput("reset_result", oResult, 64'd0);
    iRST = 1'b0;

    applyStimulus("mul_neg", OPMUL, -64'd7, 64'd6, 1'b0, 1'b0);
    checkOutput("mul_neg_const", lastRes, 64'hFFFF_FFFF_FFFF_FFD6);
    applyStimulus("mulhu_max", OPMULHU, '1, '1, 1'b0, 1'b0);
    checkOutput("mulhu_max_const", lastRes, 64'hFFFF_FFFF_FFFF_FFFE);
    applyStimulus("mulh_m1", OPMULH, '1, '1, 1'b0, 1'b0);
    applyStimulus("mulhsu", OPMULHSU, '1, 64'd2, 1'b0, 1'b0);
    applyStimulus("div_neg", OPDIV, -64'd20, 64'd3, 1'b0, 1'b0);
    checkOutput("div_neg_const", lastRes, -64'd6);
    applyStimulus("rem_neg", OPREM, -64'd20, 64'd3, 1'b0, 1'b0);
    checkOutput("rem_neg_const", lastRes, -64'd2);
    applyStimulus("divu", OPDIVU, 64'd20, 64'd3, 1'b0, 1'b0);
    applyStimulus("remu", OPREMU, 64'd20, 64'd3, 1'b0, 1'b0);
    applyStimulus("div_zero", OPDIV, 64'd5, 64'd0, 1'b0, 1'b0);
    applyStimulus("divu_zero", OPDIVU, 64'd5, 64'd0, 1'b0, 1'b0);
    applyStimulus("rem_zero", OPREM, 64'd5, 64'd0, 1'b0, 1'b0);
    applyStimulus("div_ovf", OPDIV, MIN_NEG, '1, 1'b0, 1'b0);
    applyStimulus("rem_ovf", OPREM, MIN_NEG, '1, 1'b0, 1'b0);

    applyStimulus("held_start", OPMUL, 64'd3, 64'd5, 1'b1, 1'b0);
    applyStimulus("scramble", OPDIVU, 64'd1000003, 64'd17, 1'b0, 1'b1);

    // Non-mul/div opcode with start must be ignored
    sawActivity = 1'b0;
    @(negedge iCLK);
    iStart   = 1'b1;
    iControl = OPADD;
    iA       = 64'd9;
    iB       = 64'd4;
    for (int j = 0; j < 5; j++) begin
      @(negedge iCLK);
      if (j == 1) iStart = 1'b0;
      if (oBusy || oDone) sawActivity = 1'b1;
    end
    checkOutput("opadd_ignored", {63'd0, sawActivity}, 64'd0);

    // Reset in the middle of CALC aborts the operation
    @(negedge iCLK);
    iStart   = 1'b1;
    iControl = OPMUL;
    iA       = 64'd123456789;
    iB       = 64'd987654321;
    @(posedge iCLK);
    #1;
    iStart = 1'b0;
    repeat (31) @(negedge iCLK);
    checkOutput("midop_busy", {62'd0, oBusy, oDone}, 64'd2);
    iRST = 1'b1;
    @(negedge iCLK);
    checkOutput("abort_busy", {62'd0, oBusy, oDone}, 64'd0);
    checkOutput("abort_result", oResult, 64'd0);
    iRST = 1'b0;
    donePulses  = 0;
    sawActivity = 1'b0;
    for (int j = 0; j < 80; j++) begin
      @(negedge iCLK);
      if (oDone) donePulses++;
      if (oBusy) sawActivity = 1'b1;
    end
    checkOutput("abort_nodone", 64'(donePulses), 64'd0);
    checkOutput("abort_nobusy", {63'd0, sawActivity}, 64'd0);
    applyStimulus("after_reset", OPMUL, 64'd3, 64'd4, 1'b0, 1'b0);
    checkOutput("after_reset_const", lastRes, 64'd12);

    // Randomized operations with occasional special operand values
    for (int i = 0; i < 40; i++) begin
      op = opList[$urandom_range(0, 7)];
      a  = {$urandom, $urandom};
      b  = {$urandom, $urandom};
      case ($urandom_range(0, 6))
        0: b = {32'd0, 32'($urandom_range(1, 1000))};
        1: b = -{32'd0, 32'($urandom_range(1, 1000))};
        2: b = '0;
        3: begin a = MIN_NEG; b = '1; end
        4: a = -{32'd0, $urandom};
        default: begin end
      endcase
      applyStimulus($sformatf("rand%0d", i), op, a, b, 1'b0, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
